// File: rtl/cardinal_hazard_ctrl.sv
// Hazard and forwarding controller for the cardinal pipeline (IF, ID, EX/MEM, WB).
// It detects load-use and ID-stage source hazards. It stalls the front end for the
// multi-cycle ALU ops (VDIV, VMOD, VSQRT). It forwards WB data to ID, merged per PPP
// lane. It also keeps a saturating count of stalled cycles.
// Data bit numbering: spec bit 0 is the MSB, so spec bit i maps to vector bit DATA_W-1-i.
//
// state | meaning
// IDLE  | no multi-cycle op in progress; a new VDIV/VMOD/VSQRT may start here
// BUSY  | multi-cycle op in progress; count holds the remaining BUSY cycles minus one
module cardinal_hazard_ctrl #(
  parameter int DATA_W   = 64,
  parameter int REG_AW   = 5,
  parameter int DIV_LAT  = 4,
  parameter int SQRT_LAT = 6,
  parameter int STAT_W   = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_func,
  input  logic [REG_AW-1:0] id_src_a,
  input  logic [REG_AW-1:0] id_src_b,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_wr,
  input  logic [2:0]        wb_ppp,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_a_data,
  input  logic [DATA_W-1:0] rf_b_data,
  output logic [DATA_W-1:0] opr_a,
  output logic [DATA_W-1:0] opr_b,
  output logic              stall,
  output logic              bubble_ex,
  output logic              mc_busy,
  output logic [STAT_W-1:0] stall_cnt
);

  localparam logic [5:0] OP_R_ALU = 6'b101010;
  localparam logic [5:0] OP_STORE = 6'b100001;
  localparam logic [5:0] OP_BEZ   = 6'b100010;
  localparam logic [5:0] OP_BNEZ  = 6'b100011;
  localparam logic [5:0] FN_VDIV  = 6'b001110;
  localparam logic [5:0] FN_VMOD  = 6'b001111;
  localparam logic [5:0] FN_VSQRT = 6'b010010;

  localparam int MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               mc_done;

  logic               early;
  logic               match_a;
  logic               match_b;
  logic               hz_stall;
  logic               is_sqrt;
  logic               mc_start;
  logic               mc_go;
  logic               mc_stall;
  logic [31:0]        lat_sel;
  logic               fwd_a;
  logic               fwd_b;
  logic [DATA_W-1:0]  lane_mask;

  // Hazard detection and the multi-cycle start condition.
  always_comb begin
    early    = (id_opcode == OP_STORE) || (id_opcode == OP_BEZ) || (id_opcode == OP_BNEZ);
    match_a  = ex_reg_wr && (ex_rd == id_src_a) && (id_src_a != '0);
    match_b  = ex_reg_wr && (ex_rd == id_src_b) && (id_src_b != '0);
    hz_stall = id_valid && ((match_a && (ex_mem_rd || early)) || (match_b && ex_mem_rd));
    is_sqrt  = (id_func == FN_VSQRT);
    mc_start = id_valid && (id_opcode == OP_R_ALU) &&
               ((id_func == FN_VDIV) || (id_func == FN_VMOD) || is_sqrt);
    lat_sel  = is_sqrt ? 32'(SQRT_LAT) : 32'(DIV_LAT);
    // The hazard is resolved first; the FSM starts only in a cycle with no hazard.
    mc_go    = (state == IDLE) && mc_start && !mc_done && !hz_stall;
    mc_stall = mc_go || (state == BUSY);
    stall    = hz_stall || mc_stall;
    bubble_ex = hz_stall && !mc_stall;
    mc_busy  = (state == BUSY);
  end

  // Multi-cycle FSM. The start cycle plus LAT-1 BUSY cycles gives LAT stalled cycles.
  // mc_done then stops the held instruction from restarting the FSM.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      count   <= '0;
      mc_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_go) begin
            if (lat_sel <= 32'd1) begin
              mc_done <= 1'b1;
            end else begin
              state <= BUSY;
              count <= CNT_W'(lat_sel - 32'd2);
            end
          end else if (!stall) begin
            mc_done <= 1'b0;
          end
        end
        BUSY: begin
          if (count == '0) begin
            state   <= IDLE;
            mc_done <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Lane mask built from WB PPP, indexed in MSB-first spec bit order.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (wb_ppp)
        3'b001:  lane_mask[DATA_W-1-i] = (i < DATA_W/2);
        3'b010:  lane_mask[DATA_W-1-i] = (i >= DATA_W/2);
        3'b011:  lane_mask[DATA_W-1-i] = (((i / 8) % 2) == 0);
        3'b100:  lane_mask[DATA_W-1-i] = (((i / 8) % 2) == 1);
        default: lane_mask[DATA_W-1-i] = 1'b1;
      endcase
    end
  end

  // WB->ID forwarding with partial-lane merge.
  always_comb begin
    fwd_a = wb_reg_wr && (wb_rd == id_src_a) && (id_src_a != '0);
    fwd_b = wb_reg_wr && (wb_rd == id_src_b) && (id_src_b != '0);
    opr_a = fwd_a ? ((wb_data & lane_mask) | (rf_a_data & ~lane_mask)) : rf_a_data;
    opr_b = fwd_b ? ((wb_data & lane_mask) | (rf_b_data & ~lane_mask)) : rf_b_data;
  end

endmodule

// File: tb/tb_cardinal_hazard_ctrl.sv
// Self-checking bench for cardinal_hazard_ctrl. It applies a vector table plus
// hand-written multi-cycle sequences. Expected results go through a scoreboard queue.
module tb_cardinal_hazard_ctrl;

  localparam logic [5:0] R_ALU = 6'b101010;
  localparam logic [5:0] LOAD  = 6'b100000;
  localparam logic [5:0] STORE = 6'b100001;
  localparam logic [5:0] BEZ   = 6'b100010;
  localparam logic [5:0] BNEZ  = 6'b100011;
  localparam logic [5:0] VDIV  = 6'b001110;
  localparam logic [5:0] VMOD  = 6'b001111;
  localparam logic [5:0] VSQRT = 6'b010010;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        id_valid;
  logic [5:0]  id_opcode, id_func;
  logic [4:0]  id_src_a, id_src_b, ex_rd, wb_rd;
  logic        ex_reg_wr, ex_mem_rd, wb_reg_wr;
  logic [2:0]  wb_ppp;
  logic [63:0] wb_data, rf_a_data, rf_b_data, opr_a, opr_b;
  logic        stall, bubble_ex, mc_busy;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        rst, valid;
    logic [5:0]  op, func;
    logic [4:0]  sa, sb, exrd, wbrd;
    logic        exwr, exld, wbwr;
    logic [2:0]  ppp;
    logic [63:0] wbd, rfa, rfb;
    logic        e_stall, e_bub, e_busy;
    logic        chk_opr;
    logic [63:0] e_a, e_b;
    logic        chk_cnt;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t sb_q[$];
  vec_t table_v[$];

  cardinal_hazard_ctrl #(.DATA_W(64), .REG_AW(5), .DIV_LAT(4), .SQRT_LAT(6), .STAT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_func(id_func), .id_src_a(id_src_a), .id_src_b(id_src_b), .ex_rd(ex_rd),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .wb_ppp(wb_ppp), .wb_data(wb_data), .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
    .opr_a(opr_a), .opr_b(opr_b), .stall(stall), .bubble_ex(bubble_ex),
    .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  always #5 Clock = ~Clock;

  function automatic vec_t mkv(string name, logic valid, logic [5:0] op, logic [5:0] func,
                               logic [4:0] sa, logic [4:0] sb, logic [4:0] exrd,
                               logic exwr, logic exld, logic e_stall, logic e_bub);
    vec_t v;
    v.name = name; v.rst = 1'b0; v.valid = valid; v.op = op; v.func = func;
    v.sa = sa; v.sb = sb; v.exrd = exrd; v.exwr = exwr; v.exld = exld;
    v.wbrd = '0; v.wbwr = 1'b0; v.ppp = '0; v.wbd = '0; v.rfa = '0; v.rfb = '0;
    v.e_stall = e_stall; v.e_bub = e_bub; v.e_busy = 1'b0;
    v.chk_opr = 1'b0; v.e_a = '0; v.e_b = '0; v.chk_cnt = 1'b0; v.e_cnt = '0;
    return v;
  endfunction

  function automatic vec_t mkf(string name, logic [4:0] sa, logic [4:0] sb, logic [4:0] wbrd,
                               logic wbwr, logic [2:0] ppp, logic [63:0] wbd,
                               logic [63:0] rfa, logic [63:0] rfb,
                               logic [63:0] e_a, logic [63:0] e_b);
    vec_t v;
    v = mkv(name, 1'b0, R_ALU, 6'd0, sa, sb, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    v.wbrd = wbrd; v.wbwr = wbwr; v.ppp = ppp; v.wbd = wbd; v.rfa = rfa; v.rfb = rfb;
    v.chk_opr = 1'b1; v.e_a = e_a; v.e_b = e_b;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_front();
    vec_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, ".stall"}, 64'(stall), 64'(e.e_stall));
    chk({e.name, ".bubble_ex"}, 64'(bubble_ex), 64'(e.e_bub));
    chk({e.name, ".mc_busy"}, 64'(mc_busy), 64'(e.e_busy));
    if (e.chk_opr) begin
      chk({e.name, ".opr_a"}, opr_a, e.e_a);
      chk({e.name, ".opr_b"}, opr_b, e.e_b);
    end
    if (e.chk_cnt) chk({e.name, ".stall_cnt"}, 64'(stall_cnt), 64'(e.e_cnt));
  endtask

  task automatic apply(input vec_t v);
    @(posedge Clock); #1;
    Reset = v.rst; id_valid = v.valid; id_opcode = v.op; id_func = v.func;
    id_src_a = v.sa; id_src_b = v.sb; ex_rd = v.exrd; ex_reg_wr = v.exwr; ex_mem_rd = v.exld;
    wb_rd = v.wbrd; wb_reg_wr = v.wbwr; wb_ppp = v.ppp; wb_data = v.wbd;
    rf_a_data = v.rfa; rf_b_data = v.rfb;
    sb_q.push_back(v);
    @(negedge Clock);
    compare_front();
  endtask

  task automatic do_reset();
    @(posedge Clock); #1;
    Reset = 1'b1; id_valid = 1'b0; ex_reg_wr = 1'b0; wb_reg_wr = 1'b0;
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    Reset = 1'b1; id_valid = 1'b0; id_opcode = '0; id_func = '0; id_src_a = '0; id_src_b = '0;
    ex_rd = '0; ex_reg_wr = 1'b0; ex_mem_rd = 1'b0; wb_rd = '0; wb_reg_wr = 1'b0;
    wb_ppp = '0; wb_data = '0; rf_a_data = '0; rf_b_data = '0;
    do_reset();

    // Reset state
    v = mkv("reset_state", 1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    v.chk_cnt = 1'b1; v.e_cnt = 4'd0;
    apply(v);

    // Combinational hazard and forwarding table
    table_v.push_back(mkv("load_use_b",   1, R_ALU, 6'd0, 5'd1, 5'd5, 5'd5, 1, 1, 1, 1));
    table_v.push_back(mkv("load_use_done",1, R_ALU, 6'd0, 5'd1, 5'd5, 5'd5, 0, 0, 0, 0));
    table_v.push_back(mkv("bnez_alu_a",   1, BNEZ,  6'd0, 5'd7, 5'd0, 5'd7, 1, 0, 1, 1));
    table_v.push_back(mkv("add_alu_a",    1, R_ALU, 6'd0, 5'd7, 5'd0, 5'd7, 1, 0, 0, 0));
    table_v.push_back(mkv("store_alu_b",  1, STORE, 6'd0, 5'd1, 5'd7, 5'd7, 1, 0, 0, 0));
    table_v.push_back(mkv("bez_alu_a",    1, BEZ,   6'd0, 5'd7, 5'd2, 5'd7, 1, 0, 1, 1));
    table_v.push_back(mkv("load_use_a",   1, LOAD,  6'd0, 5'd9, 5'd2, 5'd9, 1, 1, 1, 1));
    table_v.push_back(mkv("invalid_id",   0, R_ALU, 6'd0, 5'd9, 5'd2, 5'd9, 1, 1, 0, 0));
    table_v.push_back(mkv("vmod_invalid", 0, R_ALU, VMOD, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0));
    table_v.push_back(mkf("ppp000", 5'd3, 5'd4, 5'd3, 1, 3'b000, ONES, 64'd0, 64'h55, ONES, 64'h55));
    table_v.push_back(mkf("ppp001", 5'd3, 5'd4, 5'd3, 1, 3'b001, ONES, 64'd0, 64'h55,
                          64'hFFFF_FFFF_0000_0000, 64'h55));
    table_v.push_back(mkf("ppp010", 5'd3, 5'd4, 5'd3, 1, 3'b010, ONES, 64'd0, 64'h55,
                          64'h0000_0000_FFFF_FFFF, 64'h55));
    table_v.push_back(mkf("ppp011", 5'd3, 5'd4, 5'd3, 1, 3'b011, ONES, 64'd0, 64'h55,
                          64'hFF00_FF00_FF00_FF00, 64'h55));
    table_v.push_back(mkf("ppp100", 5'd3, 5'd4, 5'd3, 1, 3'b100, ONES, 64'd0, 64'h55,
                          64'h00FF_00FF_00FF_00FF, 64'h55));
    table_v.push_back(mkf("ppp111", 5'd3, 5'd4, 5'd3, 1, 3'b111, ONES, 64'd0, 64'h55, ONES, 64'h55));
    table_v.push_back(mkf("fwd_b_ppp001", 5'd2, 5'd6, 5'd6, 1, 3'b001, 64'hFEDC_BA98_7654_3210,
                          64'h1111, 64'h0123_4567_89AB_CDEF, 64'h1111, 64'hFEDC_BA98_89AB_CDEF));
    table_v.push_back(mkf("no_wb_wr", 5'd3, 5'd4, 5'd3, 0, 3'b000, ONES, 64'h77, 64'h88, 64'h77, 64'h88));
    table_v.push_back(mkf("wb_rd_miss", 5'd3, 5'd4, 5'd9, 1, 3'b000, ONES, 64'h77, 64'h88, 64'h77, 64'h88));
    v = mkf("zero_src", 5'd0, 5'd0, 5'd0, 1, 3'b000, ONES, 64'h1234, 64'h55, 64'h1234, 64'h55);
    v.valid = 1'b1; v.exrd = 5'd0; v.exwr = 1'b1; v.exld = 1'b1;
    table_v.push_back(v);

    foreach (table_v[i]) apply(table_v[i]);

    // VSQRT: 6 stalled cycles, BUSY for 5, then released without restarting
    do_reset();
    for (int c = 0; c < 8; c++) begin
      v = mkv("vsqrt", (c < 7), R_ALU, VSQRT, 5'd1, 5'd2, 5'd0, 0, 0, (c < 6), 0);
      v.e_busy = (c >= 1 && c <= 5);
      if (c == 6) begin v.chk_cnt = 1'b1; v.e_cnt = 4'd6; end
      apply(v);
    end

    // Reset during a VDIV stall
    do_reset();
    for (int c = 0; c < 4; c++) begin
      v = mkv("vdiv_rst", (c < 2), R_ALU, VDIV, 5'd1, 5'd2, 5'd0, 0, 0, (c < 3), 0);
      v.rst = (c == 2);
      v.e_busy = (c == 1 || c == 2);
      if (c == 3) begin v.chk_cnt = 1'b1; v.e_cnt = 4'd0; end
      apply(v);
    end

    // Hazard and multi-cycle start coincide: the bubble comes first, then the FSM starts
    do_reset();
    apply(mkv("hz_then_mc0", 1, R_ALU, VDIV, 5'd4, 5'd2, 5'd4, 1, 1, 1, 1));
    apply(mkv("hz_then_mc1", 1, R_ALU, VDIV, 5'd4, 5'd2, 5'd4, 0, 0, 1, 0));
    v = mkv("hz_then_mc2", 1, R_ALU, VDIV, 5'd4, 5'd2, 5'd4, 0, 0, 1, 0);
    v.e_busy = 1'b1;
    apply(v);

    // Stall counter saturation (4-bit counter)
    do_reset();
    for (int c = 0; c < 20; c++) begin
      v = mkv("sat", 1, R_ALU, 6'd0, 5'd5, 5'd0, 5'd5, 1, 1, 1, 1);
      if (c == 19) begin v.chk_cnt = 1'b1; v.e_cnt = 4'hF; end
      apply(v);
    end
    v = mkv("sat_hold", 0, R_ALU, 6'd0, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0);
    v.chk_cnt = 1'b1; v.e_cnt = 4'hF;
    apply(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
